// File: rtl/ds_terrain_engine.sv
// Diamond-square height-map generator. It fills a (2^LOG_DIM+1)^2 grid held in one RAM,
// starting from four seeded corners, and then streams the grid out in raster order.
module ds_terrain_engine #(
  parameter int LOG_DIM = 8,
  parameter int ZW      = 20,
  parameter int SHIFT0  = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [31:0]          seed,
  input  logic                 noise_en,
  input  logic signed [ZW-1:0] corner_tl,
  input  logic signed [ZW-1:0] corner_tr,
  input  logic signed [ZW-1:0] corner_bl,
  input  logic signed [ZW-1:0] corner_br,
  output logic                 busy,
  output logic                 done,
  output logic [LOG_DIM:0]     out_x,
  output logic [LOG_DIM:0]     out_y,
  output logic signed [ZW-1:0] out_z,
  output logic                 out_valid,
  input  logic                 out_ready
);
  localparam int DIM  = (1 << LOG_DIM) + 1;
  localparam int NPTS = DIM * DIM;
  localparam int AW   = $clog2(NPTS);
  localparam int CW   = LOG_DIM + 2;
  localparam logic [CW-1:0]        LAST = CW'(DIM - 1);
  localparam logic [31:0]          TAPS = 32'h8020_0003;
  localparam logic signed [ZW-1:0] ZMAX = {1'b0, {(ZW-1){1'b1}}};
  localparam logic signed [ZW-1:0] ZMIN = {1'b1, {(ZW-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE, S_CORNERS, S_DIAMOND, S_SQUARE, S_READOUT, S_DONE
  } state_t;

  state_t               state, state_d;
  logic [2:0]           ph, ph_d;
  logic [CW-1:0]        cx, cy, step, half;
  logic [3:0]           level;
  logic [31:0]          lfsr, lfsr_next;
  logic                 noise_q;
  logic signed [ZW-1:0] tl_q, tr_q, bl_q, br_q;
  logic signed [ZW+1:0] acc;

  logic [CW-1:0]        x_step, y_step, y_half, nx, ny;
  logic                 row_end, diamond_done, square_done, ro_last, in_pass;
  logic [1:0]           rk;
  logic [AW-1:0]        raddr, waddr;
  logic                 we;
  logic signed [ZW-1:0] wdata, ram_q;
  logic signed [ZW-1:0] lfsr_z, avg, r, znew;
  logic signed [ZW:0]   zsum;
  logic signed [ZW-1:0] mem [NPTS];

  function automatic logic [AW-1:0] addr_of(input logic [CW-1:0] x, input logic [CW-1:0] y);
    return AW'(y) * AW'(DIM) + AW'(x);
  endfunction

  always_comb begin
    x_step       = cx + step;
    y_step       = cy + step;
    y_half       = cy + half;
    row_end      = x_step > LAST;
    diamond_done = row_end && (y_step > LAST);
    square_done  = row_end && (y_half > LAST);
    ro_last      = (cx == LAST) && (cy == LAST);
    in_pass      = (state == S_DIAMOND) || (state == S_SQUARE);
    rk           = 2'(ph - 3'd1);
  end

  // Read address: neighbour k during a pass (off-grid mirrored), next raster point on a transfer
  always_comb begin
    nx = cx;
    ny = cy;
    if (state == S_DIAMOND) begin
      nx = rk[0] ? cx + half : cx - half;
      ny = rk[1] ? cy + half : cy - half;
    end else if (state == S_SQUARE) begin
      case (rk)
        2'd0:    nx = (cx < half) ? cx + half : cx - half;
        2'd1:    nx = (cx + half > LAST) ? cx - half : cx + half;
        2'd2:    ny = (cy < half) ? cy + half : cy - half;
        default: ny = (cy + half > LAST) ? cy - half : cy + half;
      endcase
    end else if (state == S_READOUT && ph == 3'd2 && out_ready && !ro_last) begin
      if (cx == LAST) begin
        nx = '0;
        ny = cy + CW'(1);
      end else begin
        nx = cx + CW'(1);
      end
    end
    raddr = addr_of(nx, ny);
  end

  always_comb begin
    lfsr_next = {1'b0, lfsr[31:1]} ^ (lfsr[0] ? TAPS : 32'd0);
    lfsr_z    = lfsr[ZW-1:0];
    avg       = ZW'(acc >>> 2);
    r         = '0;
    if (noise_q) r = lfsr_z >>> (SHIFT0 + int'(level));
    zsum = {avg[ZW-1], avg} + {r[ZW-1], r};
    if (zsum[ZW] != zsum[ZW-1]) znew = zsum[ZW] ? ZMIN : ZMAX;
    else                        znew = zsum[ZW-1:0];
  end

  always_comb begin
    we    = 1'b0;
    waddr = addr_of(cx, cy);
    wdata = znew;
    if (state == S_CORNERS) begin
      we = 1'b1;
      case (ph)
        3'd0:    begin waddr = addr_of('0, '0);     wdata = tl_q; end
        3'd1:    begin waddr = addr_of(LAST, '0);   wdata = tr_q; end
        3'd2:    begin waddr = addr_of('0, LAST);   wdata = bl_q; end
        default: begin waddr = addr_of(LAST, LAST); wdata = br_q; end
      endcase
    end else if (in_pass && ph == 3'd6) begin
      we = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    ram_q <= mem[raddr];
  end

  always_comb begin
    state_d = state;
    ph_d    = ph;
    case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_CORNERS;
          ph_d    = '0;
        end
      end
      S_CORNERS: begin
        if (ph == 3'd3) begin
          state_d = S_DIAMOND;
          ph_d    = '0;
        end else begin
          ph_d = ph + 3'd1;
        end
      end
      S_DIAMOND: begin
        if (ph != 3'd6)        ph_d = ph + 3'd1;
        else if (!diamond_done) ph_d = 3'd1;
        else begin
          state_d = S_SQUARE;
          ph_d    = '0;
        end
      end
      S_SQUARE: begin
        if (ph != 3'd6)       ph_d = ph + 3'd1;
        else if (!square_done) ph_d = 3'd1;
        else begin
          state_d = (half == CW'(1)) ? S_READOUT : S_DIAMOND;
          ph_d    = '0;
        end
      end
      S_READOUT: begin
        if (ph != 3'd2) ph_d = ph + 3'd1;
        else if (out_ready) begin
          if (ro_last) state_d = S_DONE;
          else         ph_d = 3'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      ph    <= '0;
    end else begin
      state <= state_d;
      ph    <= ph_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy      <= 1'b0;
      done      <= 1'b0;
      out_valid <= 1'b0;
      out_x     <= '0;
      out_y     <= '0;
      out_z     <= '0;
      cx        <= '0;
      cy        <= '0;
      step      <= '0;
      half      <= '0;
      level     <= '0;
      lfsr      <= 32'd1;
      noise_q   <= 1'b0;
      acc       <= '0;
      tl_q      <= '0;
      tr_q      <= '0;
      bl_q      <= '0;
      br_q      <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            busy    <= 1'b1;
            done    <= 1'b0;
            lfsr    <= (seed == 32'd0) ? 32'd1 : seed;
            noise_q <= noise_en;
            tl_q    <= corner_tl;
            tr_q    <= corner_tr;
            bl_q    <= corner_bl;
            br_q    <= corner_br;
            step    <= CW'(1) << LOG_DIM;
            half    <= CW'(1) << (LOG_DIM - 1);
            level   <= '0;
          end
        end
        S_DIAMOND, S_SQUARE: begin
          if (ph == 3'd0) begin
            cx <= half;
            cy <= (state == S_DIAMOND) ? half : '0;
          end else if (ph == 3'd1) begin
            acc <= '0;
          end else if (ph <= 3'd5) begin
            acc <= acc + {{2{ram_q[ZW-1]}}, ram_q};
          end else begin
            lfsr <= lfsr_next;
            if (!row_end) begin
              cx <= x_step;
            end else if (state == S_DIAMOND) begin
              if (!diamond_done) begin
                cx <= half;
                cy <= y_step;
              end
            end else if (!square_done) begin
              cy <= y_half;
              cx <= ((y_half & (step - CW'(1))) == '0) ? half : '0;
            end else begin
              step  <= half;
              half  <= half >> 1;
              level <= level + 4'd1;
              cx    <= '0;
              cy    <= '0;
            end
          end
        end
        S_READOUT: begin
          if (ph == 3'd1) begin
            out_valid <= 1'b1;
            out_x     <= cx[LOG_DIM:0];
            out_y     <= cy[LOG_DIM:0];
            out_z     <= ram_q;
          end else if (ph == 3'd2 && out_ready) begin
            out_valid <= 1'b0;
            if (ro_last) begin
              busy <= 1'b0;
              done <= 1'b1;
            end else begin
              cx <= nx;
              cy <= ny;
            end
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_ds_terrain_engine.sv
// Directed bench for ds_terrain_engine: three instances (LOG_DIM 1, 2, 3) sharing stimulus,
// with the selected instance's outputs observed through a mux.
module tb_ds_terrain_engine;
  localparam int ZW = 20;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 reset;
  logic [2:0]           start_v;
  logic [31:0]          seed;
  logic                 noise_en;
  logic signed [ZW-1:0] c_tl, c_tr, c_bl, c_br;
  logic                 out_ready;
  logic [2:0]           busy_v, done_v, valid_v;
  logic [1:0]           x0, y0;
  logic [2:0]           x1, y1;
  logic [3:0]           x2, y2;
  logic signed [ZW-1:0] z0, z1, z2;

  ds_terrain_engine #(.LOG_DIM(1), .ZW(ZW), .SHIFT0(4)) dut1 (
    .clk(clk), .reset(reset), .start(start_v[0]), .seed(seed), .noise_en(noise_en),
    .corner_tl(c_tl), .corner_tr(c_tr), .corner_bl(c_bl), .corner_br(c_br),
    .busy(busy_v[0]), .done(done_v[0]), .out_x(x0), .out_y(y0), .out_z(z0),
    .out_valid(valid_v[0]), .out_ready(out_ready));

  ds_terrain_engine #(.LOG_DIM(2), .ZW(ZW), .SHIFT0(4)) dut2 (
    .clk(clk), .reset(reset), .start(start_v[1]), .seed(seed), .noise_en(noise_en),
    .corner_tl(c_tl), .corner_tr(c_tr), .corner_bl(c_bl), .corner_br(c_br),
    .busy(busy_v[1]), .done(done_v[1]), .out_x(x1), .out_y(y1), .out_z(z1),
    .out_valid(valid_v[1]), .out_ready(out_ready));

  ds_terrain_engine #(.LOG_DIM(3), .ZW(ZW), .SHIFT0(4)) dut3 (
    .clk(clk), .reset(reset), .start(start_v[2]), .seed(seed), .noise_en(noise_en),
    .corner_tl(c_tl), .corner_tr(c_tr), .corner_bl(c_bl), .corner_br(c_br),
    .busy(busy_v[2]), .done(done_v[2]), .out_x(x2), .out_y(y2), .out_z(z2),
    .out_valid(valid_v[2]), .out_ready(out_ready));

  int                   sel;
  logic                 busy, done, valid;
  logic [3:0]           ox, oy;
  logic signed [ZW-1:0] oz;

  always_comb begin
    busy  = busy_v[sel];
    done  = done_v[sel];
    valid = valid_v[sel];
    case (sel)
      0:       begin ox = {2'b00, x0}; oy = {2'b00, y0}; oz = z0; end
      1:       begin ox = {1'b0, x1};  oy = {1'b0, y1};  oz = z1; end
      default: begin ox = x2;          oy = y2;          oz = z2; end
    endcase
  end

  int n_pass = 0;
  int n_total = 0;

  logic signed [ZW-1:0] zq[$];
  int                   xq[$], yq[$];
  int                   first_cyc;
  logic                 timed_out, stall_ok, done_early;
  logic                 end_busy, end_done, end_valid, post_busy, post_done;

  int exp1[9] = '{100, 200, 200, 225, 250, 275, 300, 300, 400};

  // Starts instance d, collects n beats; optional stall at beat stall_at; poke pulses start mid-stream and on the final transfer
  task automatic run_stream(input int d, input int n, input int stall_at, input int stall_len, input bit poke);
    int cyc, beats;
    bit stalled;
    logic [3:0] hx, hy;
    logic signed [ZW-1:0] hz;
    zq.delete(); xq.delete(); yq.delete();
    sel = d; out_ready = 1'b1;
    first_cyc = -1; done_early = 1'b0; stall_ok = 1'b1; stalled = 1'b0; beats = 0;
    start_v[d] = 1'b1;
    @(posedge clk); #1;
    start_v = '0; cyc = 1;
    while (beats < n && cyc < 20000) begin
      if (done) done_early = 1'b1;
      if (valid && first_cyc < 0) first_cyc = cyc;
      if (valid && beats == stall_at && !stalled) begin
        stalled = 1'b1; hx = ox; hy = oy; hz = oz; out_ready = 1'b0;
        repeat (stall_len) begin
          @(posedge clk); #1; cyc++;
          if (!valid || ox !== hx || oy !== hy || oz !== hz) stall_ok = 1'b0;
        end
        out_ready = 1'b1;
      end
      if (valid && out_ready) begin
        zq.push_back(oz); xq.push_back(int'(ox)); yq.push_back(int'(oy));
        beats++;
        if (poke && (beats == 3 || beats == n)) start_v[d] = 1'b1;
      end
      @(posedge clk); #1; cyc++;
      start_v = '0;
    end
    timed_out = (beats < n);
    end_busy = busy; end_done = done; end_valid = valid;
    repeat (3) @(posedge clk);
    #1;
    post_busy = busy; post_done = done;
  endtask

  task automatic test_reset();
    for (int d = 0; d < 3; d++) begin
      sel = d; #1;
      n_total++;
      if ({busy, done, valid} !== 3'b000) $display("FAIL reset_flags dut%0d: busy/done/valid=%b required 000", d, {busy, done, valid});
      else n_pass++;
      n_total++;
      if (ox !== 4'd0 || oy !== 4'd0 || oz !== '0) $display("FAIL reset_outputs dut%0d: x=%0d y=%0d z=%0d required 0 0 0", d, ox, oy, oz);
      else n_pass++;
    end
  endtask

  task automatic test_basic();
    int bad;
    c_tl = 100; c_tr = 200; c_bl = 300; c_br = 400; noise_en = 1'b0; seed = 32'h1;
    run_stream(0, 9, -1, 0, 1'b0);
    n_total++;
    if (timed_out || first_cyc !== 39) $display("FAIL basic_first_valid: cycle=%0d timeout=%b required 39", first_cyc, timed_out);
    else n_pass++;
    for (int i = 0; i < 9; i++) begin
      n_total++;
      if (i >= zq.size() || zq[i] !== exp1[i]) $display("FAIL basic_z[%0d]: got %0d required %0d", i, (i < zq.size()) ? int'(zq[i]) : -1, exp1[i]);
      else n_pass++;
    end
    bad = 0;
    for (int i = 0; i < xq.size(); i++) if (xq[i] != i % 3 || yq[i] != i / 3) bad++;
    n_total++;
    if (bad != 0 || xq.size() != 9) $display("FAIL basic_coords: bad=%0d beats=%0d required 0 and 9", bad, xq.size());
    else n_pass++;
    n_total++;
    if ({end_busy, end_done, end_valid} !== 3'b010 || done_early) $display("FAIL basic_end: busy/done/valid=%b early_done=%b required 010 0", {end_busy, end_done, end_valid}, done_early);
    else n_pass++;
  endtask

  task automatic test_saturation();
    int bad;
    c_tl = 524287; c_tr = 524287; c_bl = 524287; c_br = 524287; noise_en = 1'b0;
    run_stream(1, 25, -1, 0, 1'b0);
    n_total++;
    if (timed_out || first_cyc !== 137) $display("FAIL sat_first_valid: cycle=%0d timeout=%b required 137", first_cyc, timed_out);
    else n_pass++;
    bad = 0;
    foreach (zq[i]) if (zq[i] !== 20'sd524287) bad++;
    n_total++;
    if (bad != 0 || zq.size() != 25) $display("FAIL sat_values: wrong=%0d beats=%0d required 0 and 25", bad, zq.size());
    else n_pass++;
  endtask

  task automatic test_backpressure();
    int bad;
    c_tl = 0; c_tr = 400; c_bl = 800; c_br = 1200; noise_en = 1'b0;
    run_stream(1, 25, 7, 10, 1'b0);
    n_total++;
    if (!stall_ok) $display("FAIL bp_stable: outputs changed during stall, required held");
    else n_pass++;
    bad = 0;
    for (int i = 0; i < xq.size(); i++) if (xq[i] != i % 5 || yq[i] != i / 5) bad++;
    n_total++;
    if (timed_out || bad != 0 || xq.size() != 25) $display("FAIL bp_raster: bad=%0d beats=%0d required 0 and 25", bad, xq.size());
    else n_pass++;
    n_total++;
    if (zq.size() < 8 || zq[6] !== 375 || zq[7] !== 475) $display("FAIL bp_values: z6=%0d z7=%0d required 375 475", (zq.size() > 6) ? int'(zq[6]) : -1, (zq.size() > 7) ? int'(zq[7]) : -1);
    else n_pass++;
  endtask

  task automatic test_noise();
    logic signed [ZW-1:0] ref_q[$];
    int diff;
    c_tl = 1000; c_tr = -2000; c_bl = 3000; c_br = -4000; noise_en = 1'b1; seed = 32'hACE1;
    run_stream(2, 81, -1, 0, 1'b0);
    n_total++;
    if (timed_out || first_cyc !== 475) $display("FAIL noise_first_valid: cycle=%0d timeout=%b required 475", first_cyc, timed_out);
    else n_pass++;
    n_total++;
    if (zq.size() != 81 || zq[0] !== c_tl || zq[8] !== c_tr || zq[72] !== c_bl || zq[80] !== c_br)
      $display("FAIL noise_corners: beats=%0d required 81 with corner heights 1000 -2000 3000 -4000", zq.size());
    else n_pass++;
    ref_q = zq;
    run_stream(2, 81, -1, 0, 1'b0);
    diff = 0;
    for (int i = 0; i < 81; i++) if (i >= zq.size() || i >= ref_q.size() || zq[i] !== ref_q[i]) diff++;
    n_total++;
    if (diff != 0) $display("FAIL noise_repeat: differing beats=%0d required 0", diff);
    else n_pass++;
    seed = 32'hACE2;
    run_stream(2, 81, -1, 0, 1'b0);
    diff = 0;
    for (int i = 0; i < 81; i++) if (i >= zq.size() || i >= ref_q.size() || zq[i] !== ref_q[i]) diff++;
    n_total++;
    if (diff == 0) $display("FAIL noise_seed_change: differing beats=%0d required nonzero", diff);
    else n_pass++;
    seed = 32'h0;
    run_stream(2, 81, -1, 0, 1'b0);
    ref_q = zq;
    seed = 32'h1;
    run_stream(2, 81, -1, 0, 1'b0);
    diff = 0;
    for (int i = 0; i < 81; i++) if (i >= zq.size() || i >= ref_q.size() || zq[i] !== ref_q[i]) diff++;
    n_total++;
    if (diff != 0) $display("FAIL noise_seed_zero: seed 0 vs seed 1 differing beats=%0d required 0", diff);
    else n_pass++;
    noise_en = 1'b0;
  endtask

  task automatic test_reset_mid();
    int bad;
    c_tl = 100; c_tr = 200; c_bl = 300; c_br = 400; noise_en = 1'b0;
    sel = 0;
    start_v[0] = 1'b1;
    @(posedge clk); #1;
    start_v = '0;
    repeat (19) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    n_total++;
    if (busy !== 1'b0 || valid !== 1'b0) $display("FAIL midreset_drop: busy=%b valid=%b required 0 0", busy, valid);
    else n_pass++;
    reset = 1'b0;
    run_stream(0, 9, -1, 0, 1'b0);
    bad = 0;
    for (int i = 0; i < 9; i++) if (i >= zq.size() || zq[i] !== exp1[i]) bad++;
    n_total++;
    if (timed_out || bad != 0 || first_cyc !== 39) $display("FAIL midreset_rerun: wrong=%0d first=%0d required 0 and 39", bad, first_cyc);
    else n_pass++;
  endtask

  task automatic test_start_in_readout();
    int bad;
    c_tl = 100; c_tr = 200; c_bl = 300; c_br = 400; noise_en = 1'b0;
    run_stream(0, 9, -1, 0, 1'b1);
    bad = 0;
    for (int i = 0; i < 9; i++) if (i >= zq.size() || zq[i] !== exp1[i]) bad++;
    n_total++;
    if (timed_out || bad != 0) $display("FAIL poke_stream: wrong=%0d timeout=%b required 0 0", bad, timed_out);
    else n_pass++;
    n_total++;
    if (done_early || {end_busy, end_done, end_valid} !== 3'b010) $display("FAIL poke_done_once: early=%b busy/done/valid=%b required 0 010", done_early, {end_busy, end_done, end_valid});
    else n_pass++;
    n_total++;
    if (post_busy !== 1'b0 || post_done !== 1'b1) $display("FAIL poke_final_start: busy=%b done=%b required 0 1", post_busy, post_done);
    else n_pass++;
  endtask

  initial begin
    reset = 1'b1; start_v = '0; seed = '0; noise_en = 1'b0; out_ready = 1'b1; sel = 0;
    c_tl = '0; c_tr = '0; c_bl = '0; c_br = '0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    reset = 1'b0;
    @(posedge clk); #1;
    test_basic();
    test_saturation();
    test_backpressure();
    test_noise();
    test_reset_mid();
    test_start_in_readout();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
